// File: rtl/bmp_scan_pkg.sv
// Shared definitions for the bitmap scan sequencer: default geometry,
// ALU slice selectors and the sequencer state encoding.
package bmp_scan_pkg;

    localparam int unsigned NCOLS_DEF   = 24;
    localparam int unsigned NROWS_DEF   = 64;
    localparam int unsigned TIMEOUT_DEF = 15;

    localparam logic [1:0] ALU_SEL_COL = 2'b00;
    localparam logic [1:0] ALU_SEL_TOP = 2'b01;
    localparam logic [1:0] ALU_SEL_BOT = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_COL_REQ,
        S_COL_WAIT,
        S_COL_ALU,
        S_TOP_REQ,
        S_TOP_WAIT,
        S_TOP_ALU,
        S_BOT_REQ,
        S_BOT_WAIT,
        S_BOT_ALU,
        S_DONE,
        S_ERR
    } state_e;

endpackage

// File: rtl/bmp_wait_timer.sv
// Loadable down-counter bounding how long the sequencer waits for a ready.
// load presets TIMEOUT-1; expire is high once the count has reached zero,
// i.e. during the TIMEOUT-th wait cycle after the load.
module bmp_wait_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: preset on load, otherwise count down while enabled, saturating at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(TIMEOUT - 1);
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/bmp_scan_ctrl.sv
// Bitmap scan sequencer: loads a bitmap, walks every column, then scans rows
// top-down and bottom-up, handshaking each slice into the compare ALU and
// recording the first non-empty row from each side.
module bmp_scan_ctrl
    import bmp_scan_pkg::*;
#(
    parameter int unsigned NCOLS   = NCOLS_DEF,
    parameter int unsigned NROWS   = NROWS_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       wren,
    output logic       nextcol,
    output logic       nextrowtop,
    output logic       nextrowbot,
    input  logic       colready,
    input  logic       rowtopready,
    input  logic       rowbotready,
    output logic       alu_valid,
    output logic [1:0] alu_sel,
    input  logic       alu_ack,
    input  logic       alu_hit,
    output logic       busy,
    output logic [4:0] col_idx,
    output logic [5:0] top_row,
    output logic [5:0] bot_row,
    output logic       empty,
    output logic       done,
    output logic       err
);

    localparam logic [4:0] COL_LAST = 5'(NCOLS - 1);
    localparam logic [5:0] ROW_LAST = 6'(NROWS - 1);

    state_e     state_q, state_d;
    logic [4:0] col_q, col_d;
    logic [5:0] k_q, k_d;
    logic [5:0] top_q, top_d;
    logic [5:0] bot_q, bot_d;
    logic       empty_q, empty_d;
    logic       err_q, err_d;
    logic       wren_q, wren_d;
    logic       nextcol_q, nextcol_d;
    logic       nextrowtop_q, nextrowtop_d;
    logic       nextrowbot_q, nextrowbot_d;
    logic       alu_valid_q, alu_valid_d;
    logic [1:0] alu_sel_q, alu_sel_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       tmr_load;
    logic       tmr_en;
    logic       tmr_expire;

    bmp_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .en    (tmr_en),
        .expire(tmr_expire)
    );

    // Next-state, counter and result logic; outputs are decoded from the next
    // state so every output leaves the flops aligned with the state it belongs to.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        k_d      = k_q;
        top_d    = top_q;
        bot_d    = bot_q;
        empty_d  = empty_q;
        err_d    = err_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    err_d   = 1'b0;
                    col_d   = '0;
                    k_d     = '0;
                    top_d   = ROW_LAST;
                    bot_d   = '0;
                    empty_d = 1'b0;
                end
            end
            S_LOAD: state_d = S_COL_REQ;

            S_COL_REQ: begin
                tmr_load = 1'b1;
                state_d  = S_COL_WAIT;
            end
            S_COL_WAIT: begin
                if (colready) begin
                    state_d = S_COL_ALU;
                end else if (tmr_expire) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            S_COL_ALU: begin
                if (alu_ack) begin
                    col_d = col_q + 1'b1;
                    if (col_q == COL_LAST) begin
                        state_d = S_TOP_REQ;
                        k_d     = '0;
                    end else begin
                        state_d = S_COL_REQ;
                    end
                end
            end

            S_TOP_REQ: begin
                tmr_load = 1'b1;
                state_d  = S_TOP_WAIT;
            end
            S_TOP_WAIT: begin
                if (rowtopready) begin
                    state_d = S_TOP_ALU;
                end else if (tmr_expire) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            S_TOP_ALU: begin
                if (alu_ack) begin
                    if (alu_hit) begin
                        top_d   = ROW_LAST - k_q;
                        k_d     = '0;
                        state_d = S_BOT_REQ;
                    end else if (k_q == ROW_LAST) begin
                        empty_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = S_TOP_REQ;
                    end
                end
            end

            S_BOT_REQ: begin
                tmr_load = 1'b1;
                state_d  = S_BOT_WAIT;
            end
            S_BOT_WAIT: begin
                if (rowbotready) begin
                    state_d = S_BOT_ALU;
                end else if (tmr_expire) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            S_BOT_ALU: begin
                if (alu_ack) begin
                    if (alu_hit) begin
                        bot_d   = k_q;
                        state_d = S_DONE;
                    end else if (k_q == ROW_LAST) begin
                        bot_d   = ROW_LAST;
                        state_d = S_DONE;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = S_BOT_REQ;
                    end
                end
            end

            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        wren_d       = (state_d == S_LOAD);
        nextcol_d    = (state_d == S_COL_REQ);
        nextrowtop_d = (state_d == S_TOP_REQ);
        nextrowbot_d = (state_d == S_BOT_REQ);
        alu_valid_d  = (state_d == S_COL_ALU) || (state_d == S_TOP_ALU) ||
                       (state_d == S_BOT_ALU);
        done_d       = (state_d == S_DONE);
        busy_d       = !((state_d == S_IDLE) || (state_d == S_DONE) ||
                         (state_d == S_ERR));
        unique case (state_d)
            S_TOP_ALU: alu_sel_d = ALU_SEL_TOP;
            S_BOT_ALU: alu_sel_d = ALU_SEL_BOT;
            default:   alu_sel_d = ALU_SEL_COL;
        endcase
    end

    // Sequencer state, counters, results and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            k_q          <= '0;
            top_q        <= ROW_LAST;
            bot_q        <= '0;
            empty_q      <= 1'b0;
            err_q        <= 1'b0;
            wren_q       <= 1'b0;
            nextcol_q    <= 1'b0;
            nextrowtop_q <= 1'b0;
            nextrowbot_q <= 1'b0;
            alu_valid_q  <= 1'b0;
            alu_sel_q    <= ALU_SEL_COL;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            k_q          <= k_d;
            top_q        <= top_d;
            bot_q        <= bot_d;
            empty_q      <= empty_d;
            err_q        <= err_d;
            wren_q       <= wren_d;
            nextcol_q    <= nextcol_d;
            nextrowtop_q <= nextrowtop_d;
            nextrowbot_q <= nextrowbot_d;
            alu_valid_q  <= alu_valid_d;
            alu_sel_q    <= alu_sel_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign wren       = wren_q;
    assign nextcol    = nextcol_q;
    assign nextrowtop = nextrowtop_q;
    assign nextrowbot = nextrowbot_q;
    assign alu_valid  = alu_valid_q;
    assign alu_sel    = alu_sel_q;
    assign busy       = busy_q;
    assign col_idx    = col_q;
    assign top_row    = top_q;
    assign bot_row    = bot_q;
    assign empty      = empty_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_bmp_scan_ctrl.sv
// Bench for bmp_scan_ctrl: a behavioural bitmap-register/ALU responder plus a
// scoreboard of expected scan results pushed at start and popped at done/err.
module tb_bmp_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst, start;
    logic       colready, rowtopready, rowbotready, alu_ack, alu_hit;
    logic       wren, nextcol, nextrowtop, nextrowbot, alu_valid;
    logic [1:0] alu_sel;
    logic       busy, empty, done, err;
    logic [4:0] col_idx;
    logic [5:0] top_row, bot_row;

    always #5 clk = ~clk;

    bmp_scan_ctrl #(.NCOLS(24), .NROWS(64), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .start(start),
        .wren(wren), .nextcol(nextcol), .nextrowtop(nextrowtop), .nextrowbot(nextrowbot),
        .colready(colready), .rowtopready(rowtopready), .rowbotready(rowbotready),
        .alu_valid(alu_valid), .alu_sel(alu_sel), .alu_ack(alu_ack), .alu_hit(alu_hit),
        .busy(busy), .col_idx(col_idx), .top_row(top_row), .bot_row(bot_row),
        .empty(empty), .done(done), .err(err)
    );

    int ncomp = 0;
    int nfail = 0;

    typedef struct {
        int col; int top; int bot; int emp; int er;
        int lat; int ncol; int ntop; int nbot;
    } exp_t;
    exp_t sb[$];

    // Scenario knobs read by the responder
    int cfg_top_k = -1, cfg_bot_k = -1, cfg_stall = -1, cfg_sdly = 0, cfg_dly = 0;

    // Strobe monitor results
    int n_wren = 0, n_col = 0, n_top = 0, n_bot = 0, width_err = 0, sel_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected outcome of one scan, derived from the scenario alone
    function automatic exp_t model(input int top_k, input int bot_k, input int stall,
                                   input int sdly, input int dly);
        exp_t e;
        int per;
        per = 3 + dly;
        e.col = 24; e.top = 63; e.bot = 0; e.emp = 0; e.er = 0;
        e.ncol = 24; e.ntop = 0; e.nbot = 0;
        if (stall >= 0 && sdly >= 15) begin
            e.er = 1; e.col = stall; e.ncol = stall + 1;
            e.lat = 1 + stall * per + 1 + 15 + 1;
        end else begin
            if (top_k >= 0) begin
                e.top = 63 - top_k; e.ntop = top_k + 1;
                if (bot_k >= 0) begin e.bot = bot_k; e.nbot = bot_k + 1; end
                else begin e.bot = 63; e.nbot = 64; end
            end else begin
                e.emp = 1; e.ntop = 64;
            end
            e.lat = 1 + (24 + e.ntop + e.nbot) * per + ((stall >= 0) ? sdly : 0) + 1;
        end
        return e;
    endfunction

    // Bitmap register + ALU responder
    initial begin
        int col_cd, col_seen, top_seen, bot_seen, vcnt;
        logic top_pend, bot_pend;
        col_cd = -1; col_seen = 0; top_seen = 0; bot_seen = 0; vcnt = 0;
        top_pend = 1'b0; bot_pend = 1'b0;
        colready = 1'b0; rowtopready = 1'b0; rowbotready = 1'b0;
        alu_ack = 1'b0; alu_hit = 1'b0;
        forever begin
            @(negedge clk);
            if (wren) begin
                col_seen = 0; top_seen = 0; bot_seen = 0; col_cd = -1;
            end
            if (col_cd >= 0) col_cd--;
            colready = (col_cd == 0);
            if (nextcol) begin
                col_cd = ((col_seen == cfg_stall) ? cfg_sdly : 0) + 1;
                col_seen++;
            end
            rowtopready = top_pend; top_pend = nextrowtop;
            rowbotready = bot_pend; bot_pend = nextrowbot;
            if (alu_valid) begin
                if (vcnt == cfg_dly) begin
                    alu_ack = 1'b1;
                    alu_hit = (alu_sel == 2'b00) ||
                              (alu_sel == 2'b01 && top_seen == cfg_top_k) ||
                              (alu_sel == 2'b10 && bot_seen == cfg_bot_k);
                    if (alu_sel == 2'b01) top_seen++;
                    if (alu_sel == 2'b10) bot_seen++;
                    vcnt = 0;
                end else begin
                    alu_ack = 1'b0; alu_hit = 1'b0; vcnt++;
                end
            end else begin
                alu_ack = 1'b0; alu_hit = 1'b0; vcnt = 0;
            end
        end
    end

    // Strobe counting, strobe width and alu_sel stability while a slice is held
    initial begin
        logic p_wren, p_col, p_top, p_bot, p_valid;
        logic [1:0] p_sel;
        p_wren = 0; p_col = 0; p_top = 0; p_bot = 0; p_valid = 0; p_sel = 2'b00;
        forever begin
            @(negedge clk);
            if (wren === 1'b1) n_wren++;
            if (nextcol === 1'b1) n_col++;
            if (nextrowtop === 1'b1) n_top++;
            if (nextrowbot === 1'b1) n_bot++;
            if ((wren && p_wren) || (nextcol && p_col) || (nextrowtop && p_top) ||
                (nextrowbot && p_bot)) width_err++;
            if (alu_valid && p_valid && (alu_sel !== p_sel)) sel_err++;
            p_wren = wren; p_col = nextcol; p_top = nextrowtop; p_bot = nextrowbot;
            p_valid = alu_valid; p_sel = alu_sel;
        end
    end

    task automatic check_reset_values(input string pfx);
        check({pfx, "_wren"}, 32'(wren), 32'd0);
        check({pfx, "_nextcol"}, 32'(nextcol), 32'd0);
        check({pfx, "_nextrowtop"}, 32'(nextrowtop), 32'd0);
        check({pfx, "_nextrowbot"}, 32'(nextrowbot), 32'd0);
        check({pfx, "_alu_valid"}, 32'(alu_valid), 32'd0);
        check({pfx, "_alu_sel"}, 32'(alu_sel), 32'd0);
        check({pfx, "_busy"}, 32'(busy), 32'd0);
        check({pfx, "_done"}, 32'(done), 32'd0);
        check({pfx, "_err"}, 32'(err), 32'd0);
        check({pfx, "_empty"}, 32'(empty), 32'd0);
        check({pfx, "_col_idx"}, 32'(col_idx), 32'd0);
        check({pfx, "_top_row"}, 32'(top_row), 32'd63);
        check({pfx, "_bot_row"}, 32'(bot_row), 32'd0);
    endtask

    // One scan; called at a negedge with the DUT idle, returns at a negedge.
    task automatic run_scan(input string tag, input int top_k, input int bot_k,
                            input int stall, input int sdly, input int dly, input bit poke);
        exp_t e;
        int cyc;
        cfg_top_k = top_k; cfg_bot_k = bot_k; cfg_stall = stall;
        cfg_sdly = sdly; cfg_dly = dly;
        n_wren = 0; n_col = 0; n_top = 0; n_bot = 0;
        sb.push_back(model(top_k, bot_k, stall, sdly, dly));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check({tag, "_load_wren"}, 32'(wren), 32'd1);
        check({tag, "_load_busy"}, 32'(busy), 32'd1);
        while (!(done === 1'b1 || err === 1'b1) && cyc < 3000) begin
            start = poke && (cyc == 50);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, "_finished_in_budget"}, 32'(cyc < 3000), 32'd1);
        if (sb.size() == 0) begin
            check({tag, "_scoreboard_nonempty"}, 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_latency"}, 32'(cyc), 32'(e.lat));
        check({tag, "_done"}, 32'(done), 32'(1 - e.er));
        check({tag, "_err"}, 32'(err), 32'(e.er));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_col_idx"}, 32'(col_idx), 32'(e.col));
        check({tag, "_top_row"}, 32'(top_row), 32'(e.top));
        check({tag, "_bot_row"}, 32'(bot_row), 32'(e.bot));
        check({tag, "_empty"}, 32'(empty), 32'(e.emp));
        check({tag, "_n_wren"}, 32'(n_wren), 32'd1);
        check({tag, "_n_nextcol"}, 32'(n_col), 32'(e.ncol));
        check({tag, "_n_nextrowtop"}, 32'(n_top), 32'(e.ntop));
        check({tag, "_n_nextrowbot"}, 32'(n_bot), 32'(e.nbot));
        check({tag, "_strobe_width_errs"}, 32'(width_err), 32'd0);
        check({tag, "_sel_change_errs"}, 32'(sel_err), 32'd0);
        if (poke && done === 1'b1) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_idle_after"}, 32'(busy), 32'd0);
        check({tag, "_no_restart"}, 32'(wren), 32'd0);
        check({tag, "_err_sticky"}, 32'(err), 32'(e.er));
        check({tag, "_results_held"}, 32'({col_idx, top_row, bot_row}), 32'({5'(e.col), 6'(e.top), 6'(e.bot)}));
    endtask

    initial begin
        int w;
        rst = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        // hits at top k=3 and bottom k=5, zero-wait handshakes
        run_scan("basic", 3, 5, -1, 0, 0, 1'b0);
        // all-zero bitmap
        run_scan("allzero", -1, -1, -1, 0, 0, 1'b0);
        // colready withheld at column 7
        run_scan("col_timeout", 0, 0, 7, 15, 0, 1'b0);
        // colready on the last allowed wait cycle still wins
        run_scan("col_late_ready", 0, 0, 7, 14, 0, 1'b0);
        // alu_ack delayed 4 cycles per slice
        run_scan("ack_delay", 0, 2, -1, 0, 4, 1'b0);

        // reset while a top-row slice is held at the ALU
        cfg_top_k = -1; cfg_bot_k = -1; cfg_stall = -1; cfg_dly = 3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!(alu_valid === 1'b1 && alu_sel === 2'b01) && w < 500) begin
            @(negedge clk);
            w++;
        end
        check("reach_top_alu", 32'(w < 500), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("midscan_rst");
        @(negedge clk);
        check("midscan_rst_stays_idle", 32'({busy, wren, nextcol}), 32'd0);
        run_scan("after_rst", 10, 0, -1, 0, 0, 1'b0);

        // last-row boundaries, with start poked mid-scan and on the done cycle
        run_scan("boundary_poke", 63, -1, -1, 0, 0, 1'b1);
        // start one cycle after done is accepted
        run_scan("restart", 1, 1, -1, 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
